// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline stages and the stall/flush controller.
interface pipeline_ctrl_if #(
  parameter int MC_LEN_W = 6
);
  logic                stallreq_id_i;
  logic                ex_mc_start_i;
  logic [MC_LEN_W-1:0] ex_mc_len_i;
  logic                flush_i;
  logic [5:0]          stall_o;
  logic                flush_o;
  logic                ex_mc_busy_o;
  logic                ex_mc_done_o;

  modport master (
    output stallreq_id_i, ex_mc_start_i, ex_mc_len_i, flush_i,
    input  stall_o, flush_o, ex_mc_busy_o, ex_mc_done_o
  );

  modport slave (
    input  stallreq_id_i, ex_mc_start_i, ex_mc_len_i, flush_i,
    output stall_o, flush_o, ex_mc_busy_o, ex_mc_done_o
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the five-stage pipeline with multi-cycle EX sequencing.
// Optional stalled-cycle counter enabled by defining PIPELINE_CTRL_PERF_EN.
//
// state | meaning
// IDLE  | no multi-cycle op; ID load-use stalls honoured
// BUSY  | multi-cycle op counting down, EX and earlier stalled
// DONE  | one-cycle completion pulse back to EX
module pipeline_ctrl #(
  parameter int MC_LEN_W = 6
) (
  input  logic           clk,
  input  logic           rst,
  pipeline_ctrl_if.slave bus
`ifdef PIPELINE_CTRL_PERF_EN
  ,
  output logic [31:0]    stall_cnt_o
`endif
);

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [MC_LEN_W-1:0] r_cnt;

  logic [5:0] w_stall;
  logic       w_flush;
  logic       w_busy;
  logic       w_done;

  always_comb begin
    w_stall = STALL_NONE;
    w_flush = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    if (!rst) begin
      w_busy = (r_state == BUSY);
      if (bus.flush_i) begin
        w_flush = 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.ex_mc_start_i)      w_stall = STALL_EX;
            else if (bus.stallreq_id_i) w_stall = STALL_ID;
          end
          BUSY: w_stall = STALL_EX;
          DONE: begin
            w_done  = 1'b1;
            w_stall = bus.stallreq_id_i ? STALL_ID : STALL_NONE;
          end
          default: w_stall = STALL_NONE;
        endcase
      end
    end
  end

  assign bus.stall_o      = w_stall;
  assign bus.flush_o      = w_flush;
  assign bus.ex_mc_busy_o = w_busy;
  assign bus.ex_mc_done_o = w_done;

  // The acceptance cycle is the first of L stall cycles, so BUSY runs L-1 cycles.
  always_ff @(posedge clk) begin
    if (rst || bus.flush_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.ex_mc_start_i) begin
            if (bus.ex_mc_len_i <= MC_LEN_W'(1)) begin
              r_cnt   <= '0;
              r_state <= DONE;
            end else begin
              r_cnt   <= bus.ex_mc_len_i - MC_LEN_W'(1);
              r_state <= BUSY;
            end
          end
        end
        BUSY: begin
          r_cnt <= r_cnt - MC_LEN_W'(1);
          if (r_cnt == MC_LEN_W'(1)) r_state <= DONE;
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] r_stall_cnt;

  // Saturating; flush deliberately leaves the count intact.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall[0] && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`endif

endmodule
